// File: rtl/tff_count_ctrl_pkg.sv
// Shared types for the T flip-flop counter sequencer: FSM state encoding
// and count-direction constants.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Run-control handshake and counter observation bundle between the
// requesting logic (master) and the sequencer (slave).
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic             hold;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] toggle;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, limit, hold,
        input  count, toggle, busy, done
    );

    modport slave (
        input  start, mode, limit, hold,
        output count, toggle, busy, done
    );
endinterface

// File: rtl/tff_count_ctrl_bank.sv
// Bank of T flip-flops: each bit inverts on the clock edge when its toggle
// bit is set; the whole bank clears asynchronously on reset.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] toggle,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q ^ toggle;
        end
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Up/down run sequencer for a T flip-flop counter bank. The bank value only
// ever changes through the toggle vector, toggle = count ^ next_count.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    tff_count_ctrl_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic             mode_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] step_val;

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk    (clk),
        .reset  (reset),
        .toggle (toggle),
        .q      (count)
    );

    // mode/limit are captured only on an accepted start, so mid-run changes are inert
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mode_q  <= UP;
            limit_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                mode_q  <= bus.mode;
                limit_q <= bus.limit;
            end
        end
    end

    always_comb begin
        init_val  = (mode_q == UP) ? '0 : limit_q;
        end_val   = (mode_q == UP) ? limit_q : '0;
        step_val  = (mode_q == UP) ? count + ONE : count - ONE;
        state_nxt = state;
        toggle    = '0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
                toggle    = count ^ init_val;
                state_nxt = (init_val == end_val) ? DONE : RUN;
            end
            RUN: begin
                // The end value is checked before stepping, so the counter never wraps
                if (!bus.hold) begin
                    toggle = count ^ step_val;
                    if (step_val == end_val) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.count  = count;
    assign bus.toggle = toggle;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: directed run table, hold/abort/reset sequences
// and randomized runs scored against a count-trajectory reference model.
module tb_tff_count_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   model_count = 0;

    tff_count_ctrl_if #(.WIDTH(W)) bus ();

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic m;
        int   lim;
        int   hold_at;
        int   hold_n;
        int   exp_load_tog;
        int   exp_done_edge;
        int   exp_final;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One complete run driven and scored cycle by cycle. Entered just after a
    // falling edge with the DUT idle; leaves it idle just after a falling edge.
    task automatic run(input logic m, input int lim, input int hold_at, input int hold_n,
                       input bit rnd, output int load_tog, output int done_edge,
                       output int pulses, output int final_cnt);
        int  mc, init_v, end_v, holds_left;
        bit  h;
        init_v     = m ? lim : 0;
        end_v      = m ? 0 : lim;
        mc         = model_count;
        holds_left = hold_n;
        done_edge  = -1;
        pulses     = 0;
        bus.start = 1'b1; bus.mode = m; bus.limit = lim[W-1:0]; bus.hold = 1'b0;
        #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_toggle", bus.toggle, 0);
        chk("idle_done", bus.done, 0);
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        bus.hold  = rnd ? 1'($urandom) : 1'b0;
        #1;
        chk("load_busy", bus.busy, 1);
        chk("load_done", bus.done, 0);
        chk("load_count", bus.count, mc);
        chk("load_toggle", bus.toggle, (mc ^ init_v) & 32'hF);
        load_tog = int'(bus.toggle);
        mc = init_v;
        for (int k = 1; k < 1000; k++) begin
            @(posedge clk); @(negedge clk);
            if (mc == end_v) begin
                bus.start = 1'b0;
                bus.hold  = rnd ? 1'($urandom) : 1'b0;
                #1;
                chk("done_count", bus.count, mc);
                chk("done_busy", bus.busy, 1);
                chk("done_flag", bus.done, 1);
                chk("done_toggle", bus.toggle, 0);
                if (bus.done === 1'b1) begin
                    pulses++;
                    done_edge = k;
                end
                @(posedge clk); @(negedge clk);
                bus.hold = 1'b0;
                #1;
                chk("end_busy", bus.busy, 0);
                chk("end_done", bus.done, 0);
                chk("end_toggle", bus.toggle, 0);
                chk("end_count", bus.count, mc);
                if (bus.done === 1'b1) pulses++;
                break;
            end
            if (hold_at >= 0 && mc == hold_at && holds_left > 0) begin
                h = 1'b1;
                holds_left--;
            end else begin
                h = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (rnd) begin
                bus.start = 1'($urandom);
                bus.mode  = 1'($urandom);
                bus.limit = W'($urandom);
            end
            bus.hold = h;
            #1;
            chk("run_count", bus.count, mc);
            chk("run_busy", bus.busy, 1);
            chk("run_done", bus.done, 0);
            if (bus.done === 1'b1) pulses++;
            if (h) begin
                chk("run_hold_toggle", bus.toggle, 0);
            end else begin
                chk("run_toggle", bus.toggle,
                    (mc ^ (m ? mc - 1 : mc + 1)) & 32'hF);
                mc = m ? mc - 1 : mc + 1;
            end
        end
        bus.start   = 1'b0;
        model_count = mc;
        final_cnt   = int'(bus.count);
    endtask

    initial begin
        int lt, de, pu, fc, lim;
        logic m;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lt, de, pu, fc, lim;
        logic m;
        bus.start = 1'b0; bus.mode = 1'b0; bus.limit = '0; bus.hold = 1'b0;

        // Reset asserted between edges must clear outputs without a clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_toggle", bus.toggle, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        model_count = 0;

        tbl[0] = '{1'b0,  5, -1, 0, 0,  6,  5};
        tbl[1] = '{1'b1,  3, -1, 0, 6,  4,  0};
        tbl[2] = '{1'b0,  4,  2, 3, 0,  8,  4};
        tbl[3] = '{1'b0,  0, -1, 0, 4,  1,  0};
        tbl[4] = '{1'b0, 15, -1, 0, 0, 16, 15};
        tbl[5] = '{1'b1,  0, -1, 0, 15, 1,  0};
        tbl[6] = '{1'b1, 15, -1, 0, 15, 16, 0};

        for (int i = 0; i < 7; i++) begin
            run(tbl[i].m, tbl[i].lim, tbl[i].hold_at, tbl[i].hold_n, 1'b0, lt, de, pu, fc);
            chk($sformatf("tbl%0d_load_toggle", i), lt, tbl[i].exp_load_tog);
            chk($sformatf("tbl%0d_done_edge", i), de, tbl[i].exp_done_edge);
            chk($sformatf("tbl%0d_done_pulses", i), pu, 1);
            chk($sformatf("tbl%0d_final", i), fc, tbl[i].exp_final);
        end

        // Abort: reset while a limit-10 up run sits at count 3.
        bus.start = 1'b1; bus.mode = 1'b0; bus.limit = 4'd10;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("abort_pre_count", bus.count, 3);
        chk("abort_pre_busy", bus.busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("abort_count", bus.count, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_toggle", bus.toggle, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("abort_hold_done", bus.done, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_abort_done", bus.done, 0);
        chk("post_abort_busy", bus.busy, 0);
        model_count = 0;

        run(1'b0, 5, -1, 0, 1'b0, lt, de, pu, fc);
        chk("after_abort_done_edge", de, 6);
        chk("after_abort_pulses", pu, 1);
        chk("after_abort_final", fc, 5);

        // Randomized runs with random hold and mid-run start/mode/limit noise.
        for (int r = 0; r < 24; r++) begin
            m   = 1'($urandom);
            lim = $urandom_range(0, 15);
            run(m, lim, -1, 0, 1'b1, lt, de, pu, fc);
            chk($sformatf("rnd%0d_pulses", r), pu, 1);
            chk($sformatf("rnd%0d_final", r), fc, m ? 0 : lim);
        end

        // Idle reset with a nonzero count left behind.
        run(1'b0, 7, -1, 0, 1'b0, lt, de, pu, fc);
        chk("pre_idle_rst_count", fc, 7);
        #2 reset = 1'b1;
        #1;
        chk("idle_rst_count", bus.count, 0);
        chk("idle_rst_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of toggle flip-flops used as a programmable up/down counter. Each cycle it computes the toggle vector that moves the bank from its current value to the next one (T = q XOR next). It sequences one count run with a start/busy/done handshake. It sits between the Mealy control logic and the T flip-flop state register, and is the only block allowed to drive that register's toggle inputs.

## Interface
- WIDTH, default 4: counter and limit width in bits; legal range 2..16.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request a run; sampled only in IDLE.
- mode  input  1  0 = count up from 0 to limit, 1 = count down from limit to 0; latched at start.
- limit  input  WIDTH  terminal value; latched at start.
- hold  input  1  freezes counting while high; honoured only in RUN.
- count  output  WIDTH  current T flip-flop bank value.
- toggle  output  WIDTH  toggle vector presented to the bank this cycle.
- busy  output  1  high in LOAD, RUN and DONE.
- done  output  1  high for exactly one cycle, in DONE.

## Operation
- Reset values: state IDLE, count 0, toggle 0, busy 0, done 0, latched mode/limit 0.
- The state register is the T flip-flop bank; count changes only through toggle. The invariant is toggle = count XOR next_count.
- IDLE:
  - toggle = 0.
  - start = 1 latches mode and limit, then goes to LOAD.
  - start = 0 stays in IDLE; count keeps its last value.
- LOAD:
  - Initial value is 0 for up, or latched limit for down.
  - toggle = count XOR initial.
  - Next state is DONE if initial equals the end value (limit = 0), otherwise RUN.
- RUN:
  - hold = 1: toggle = 0 and the state is unchanged.
  - Otherwise next_count = count + 1 (up) or count - 1 (down), and toggle = count XOR next_count.
  - If next_count equals the end value (limit for up, 0 for down), go to DONE on the same edge.
- DONE:
  - toggle = 0, done = 1.
  - Go unconditionally to IDLE.
  - count keeps the end value.
- start outside IDLE is ignored and is not queued. limit and mode changes during a run have no effect.
- No wrap-around: the end value is always reached before overflow or underflow, including limit = 2^WIDTH - 1.
- reset asserted in any state aborts the run. Everything returns to reset values asynchronously, with no done pulse.

## Timing
- Edges are numbered from the edge that samples start = 1 in IDLE (e0).
- e0: state becomes LOAD; busy = 1 from e0.
- e1: count = initial value; state becomes RUN, or DONE if limit = 0.
- Without hold, for limit L ≥ 1:
  - count reaches the end value at edge e(L+1), and the state becomes DONE on that edge.
  - done is high between e(L+1) and e(L+2).
  - At e(L+2) the state becomes IDLE; busy and done fall.
- Limit L = 0: done is high between e1 and e2; busy lasts 2 cycles.
- Each RUN cycle with hold = 1 adds one cycle of latency.
- toggle, busy and done are combinational from state, count and the latched registers. No outputs depend combinationally on start. hold affects only toggle.
- A new start is accepted on the first edge with state IDLE, so back-to-back runs have a 1-cycle IDLE gap.

## Structure
- Package tff_ctrl_pkg holds:
  - State typedef with IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, DONE = 2'b11.
  - Direction constants UP = 1'b0 and DOWN = 1'b1.
- Sub-module tff_bank: WIDTH toggle cells with shared clk and active-high asynchronous reset. It takes toggle in and gives q (= count) out; each bit inverts when its toggle bit is 1.
- The controller holds only the FSM, the latched mode/limit, and the next-value/toggle logic.

## Test plan
- Reset: assert reset mid-cycle with the bench idle -> count = 0, toggle = 0, busy = 0, done = 0 immediately, without waiting for a clock edge.
- Up run, WIDTH = 4, limit = 5, mode = 0:
  - count 0,1,2,3,4,5 on e1..e6.
  - done high only between e6 and e7; busy low after e7.
  - toggle always equals count XOR next_count.
- Down run, limit = 3, mode = 1:
  - Starting from count = 5 left by the previous run, LOAD toggle = 4'b0110.
  - count 3,2,1,0 on e1..e4; done after e4.
- Hold: up run with limit = 4, hold high for 3 cycles while count = 2:
  - toggle = 0 and count stays at 2 for those cycles.
  - done is delayed by exactly 3 cycles.
- Edge limits:
  - limit = 0 -> done after e1, busy 2 cycles.
  - limit = 15 up -> count 15 with no wrap, done once.
- Protocol:
  - start pulses and limit/mode changes during RUN are ignored.
  - reset at count = 3 of a limit = 10 run -> immediate IDLE, count 0, no done.
  - The next start runs normally.
